// File: rtl/stopwatch_pkg.sv
// Shared encodings for the stopwatch command path.
//   - Command codes carried on the req_cmd lanes.
//   - Control-FSM state codes. The control FSM uses the same codes.
//   - Arbiter FSM states.
//   - A legality helper that checks a command against the FSM state.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    CMD_NOP   = 2'b00,
    CMD_START = 2'b01,
    CMD_STOP  = 2'b10,
    CMD_CLEAR = 2'b11
  } cmd_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_RUNNING = 2'b01,
    ST_PAUSED  = 2'b10,
    ST_INVALID = 2'b11
  } fsm_state_e;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'b00,
    ARB_ISSUE = 2'b01,
    ARB_WAIT  = 2'b10,
    ARB_RESP  = 2'b11
  } arb_state_e;

  localparam int unsigned SETTLE_W = 4;
  localparam logic [7:0]  NACK_MAX = 8'hFF;

  // CLEAR and NOP are always accepted, even when the FSM reports the invalid code.
  function automatic logic cmd_is_legal(input logic [1:0] cmd, input logic [1:0] st);
    logic legal;
    legal = 1'b0;
    case (cmd_e'(cmd))
      CMD_NOP:   legal = 1'b1;
      CMD_START: legal = (st == ST_IDLE) || (st == ST_PAUSED);
      CMD_STOP:  legal = (st == ST_RUNNING);
      CMD_CLEAR: legal = 1'b1;
      default:   legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/stopwatch_rr_pick.sv
// Round-robin picker (combinational).
// Returns the first requester at or after the pointer. The search wraps
// past the top index back to 0.
// Ports:
//   i_req     requester vector
//   i_ptr     index where the search starts
//   o_onehot  one-hot winner (all zero when there are no requests)
//   o_idx     binary index of the winner
//   o_any     at least one request is present
module stopwatch_rr_pick #(
  parameter int unsigned NUM_SRC = 2,
  parameter int unsigned IDX_W   = $clog2(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] i_req,
  input  logic [IDX_W-1:0]   i_ptr,
  output logic [NUM_SRC-1:0] o_onehot,
  output logic [IDX_W-1:0]   o_idx,
  output logic               o_any
);

  // The outer loop walks the distance from the pointer. The inner loop maps that
  // distance to a constant index, so no select uses a computed index.
  always_comb begin
    o_onehot = '0;
    o_idx    = '0;
    o_any    = 1'b0;
    for (int k = 0; k < int'(NUM_SRC); k++) begin
      for (int j = 0; j < int'(NUM_SRC); j++) begin
        if (!o_any && i_req[j] && (((int'(i_ptr) + k) % int'(NUM_SRC)) == j)) begin
          o_any       = 1'b1;
          o_onehot[j] = 1'b1;
          o_idx       = IDX_W'(j);
        end
      end
    end
  end

endmodule

// File: rtl/stopwatch_cmd_arbiter.sv
// Stopwatch command arbiter.
// Several command sources share the stopwatch control FSM through this block.
// It grants one source at a time. It checks the command against fsm_state and
// sends a legal command as a one-cycle pulse. After the settle window it returns
// ok/nack and the FSM state to the source that was granted.
// Ports:
//   clk, rst      clock; asynchronous active-high reset
//   req_valid     per-source request
//   req_cmd       per-source command; source i uses bits [2i+1:2i]
//   req_ready     one-hot grant, high for one cycle
//   resp_valid    one-hot response strobe to the source that was granted
//   resp_ok       the command was legal and was issued
//   resp_state    fsm_state sampled in the response cycle
//   fsm_state     current state of the control FSM
//   start_pulse, stop_pulse, reset_pulse   one-cycle strobes to the FSM
//   busy          the arbiter is not idle
//   nack_count    saturating count of rejected commands
module stopwatch_cmd_arbiter
  import stopwatch_pkg::*;
#(
  parameter int unsigned NUM_SRC       = 2,
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_SRC-1:0]   req_valid,
  input  logic [2*NUM_SRC-1:0] req_cmd,
  output logic [NUM_SRC-1:0]   req_ready,
  output logic [NUM_SRC-1:0]   resp_valid,
  output logic                 resp_ok,
  output logic [1:0]           resp_state,
  input  logic [1:0]           fsm_state,
  output logic                 start_pulse,
  output logic                 stop_pulse,
  output logic                 reset_pulse,
  output logic                 busy,
  output logic [7:0]           nack_count
);

  localparam int unsigned IDX_W = $clog2(NUM_SRC);

  arb_state_e          r_state, w_state_nxt;
  logic [IDX_W-1:0]    r_ptr, w_ptr_nxt;
  logic [IDX_W-1:0]    r_win, w_win_nxt;
  logic [1:0]          r_cmd, w_cmd_nxt;
  logic                r_legal, w_legal_nxt;
  logic [SETTLE_W-1:0] r_cnt, w_cnt_nxt;

  logic [NUM_SRC-1:0]  r_req_ready, w_req_ready_nxt;
  logic [NUM_SRC-1:0]  r_resp_valid, w_resp_valid_nxt;
  logic                r_resp_ok, w_resp_ok_nxt;
  logic [1:0]          r_resp_state, w_resp_state_nxt;
  logic                r_start, w_start_nxt;
  logic                r_stop, w_stop_nxt;
  logic                r_reset, w_reset_nxt;
  logic                r_busy, w_busy_nxt;
  logic [7:0]          r_nack, w_nack_nxt;

  // Find the requesters that present CLEAR. CLEAR beats every other command.
  logic [NUM_SRC-1:0] w_clear_req;
  always_comb begin
    w_clear_req = '0;
    for (int i = 0; i < int'(NUM_SRC); i++) begin
      w_clear_req[i] = req_valid[i] && (req_cmd[2*i +: 2] == CMD_CLEAR);
    end
  end

  logic [NUM_SRC-1:0] w_clr_oh, w_vld_oh, w_win_oh;
  logic [IDX_W-1:0]   w_clr_idx, w_vld_idx, w_win_idx;
  logic               w_clr_any, w_vld_any;

  stopwatch_rr_pick #(
    .NUM_SRC (NUM_SRC),
    .IDX_W   (IDX_W)
  ) u_pick_clear (
    .i_req    (w_clear_req),
    .i_ptr    (r_ptr),
    .o_onehot (w_clr_oh),
    .o_idx    (w_clr_idx),
    .o_any    (w_clr_any)
  );

  stopwatch_rr_pick #(
    .NUM_SRC (NUM_SRC),
    .IDX_W   (IDX_W)
  ) u_pick_valid (
    .i_req    (req_valid),
    .i_ptr    (r_ptr),
    .o_onehot (w_vld_oh),
    .o_idx    (w_vld_idx),
    .o_any    (w_vld_any)
  );

  logic [1:0] w_win_cmd;
  always_comb begin
    w_win_oh  = w_clr_any ? w_clr_oh : w_vld_oh;
    w_win_idx = w_clr_any ? w_clr_idx : w_vld_idx;
    w_win_cmd = CMD_NOP;
    for (int j = 0; j < int'(NUM_SRC); j++) begin
      if (w_win_oh[j]) w_win_cmd = req_cmd[2*j +: 2];
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_ptr_nxt        = r_ptr;
    w_win_nxt        = r_win;
    w_cmd_nxt        = r_cmd;
    w_legal_nxt      = r_legal;
    w_cnt_nxt        = r_cnt;
    w_req_ready_nxt  = '0;
    w_resp_valid_nxt = '0;
    w_resp_ok_nxt    = 1'b0;
    w_resp_state_nxt = 2'b00;
    w_start_nxt      = 1'b0;
    w_stop_nxt       = 1'b0;
    w_reset_nxt      = 1'b0;
    w_nack_nxt       = r_nack;

    unique case (r_state)
      ARB_IDLE: begin
        if (w_vld_any) begin
          w_win_nxt       = w_win_idx;
          w_cmd_nxt       = w_win_cmd;
          w_req_ready_nxt = w_win_oh;
          w_state_nxt     = ARB_ISSUE;
        end
      end
      ARB_ISSUE: begin
        w_legal_nxt = cmd_is_legal(r_cmd, fsm_state);
        w_cnt_nxt   = SETTLE_W'(SETTLE_CYCLES);
        w_state_nxt = ARB_WAIT;
      end
      ARB_WAIT: begin
        // The counter still holds its load value only in the first wait cycle.
        // The pulse register is set then, so the pulse appears two cycles after the grant.
        if (r_legal && (r_cnt == SETTLE_W'(SETTLE_CYCLES))) begin
          w_start_nxt = (r_cmd == CMD_START);
          w_stop_nxt  = (r_cmd == CMD_STOP);
          w_reset_nxt = (r_cmd == CMD_CLEAR);
        end
        w_cnt_nxt = r_cnt - 1'b1;
        if (r_cnt == SETTLE_W'(1)) w_state_nxt = ARB_RESP;
      end
      ARB_RESP: begin
        w_resp_valid_nxt = {{(NUM_SRC-1){1'b0}}, 1'b1} << r_win;
        w_resp_ok_nxt    = r_legal;
        w_resp_state_nxt = fsm_state;
        if (!r_legal && (r_nack != NACK_MAX)) w_nack_nxt = r_nack + 8'd1;
        w_ptr_nxt   = (r_win == IDX_W'(NUM_SRC - 1)) ? '0 : r_win + 1'b1;
        w_state_nxt = ARB_IDLE;
      end
      default: w_state_nxt = ARB_IDLE;
    endcase

    w_busy_nxt = (w_state_nxt != ARB_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ARB_IDLE;
      r_ptr        <= '0;
      r_win        <= '0;
      r_cmd        <= 2'b00;
      r_legal      <= 1'b0;
      r_cnt        <= '0;
      r_req_ready  <= '0;
      r_resp_valid <= '0;
      r_resp_ok    <= 1'b0;
      r_resp_state <= 2'b00;
      r_start      <= 1'b0;
      r_stop       <= 1'b0;
      r_reset      <= 1'b0;
      r_busy       <= 1'b0;
      r_nack       <= 8'd0;
    end else begin
      r_state      <= w_state_nxt;
      r_ptr        <= w_ptr_nxt;
      r_win        <= w_win_nxt;
      r_cmd        <= w_cmd_nxt;
      r_legal      <= w_legal_nxt;
      r_cnt        <= w_cnt_nxt;
      r_req_ready  <= w_req_ready_nxt;
      r_resp_valid <= w_resp_valid_nxt;
      r_resp_ok    <= w_resp_ok_nxt;
      r_resp_state <= w_resp_state_nxt;
      r_start      <= w_start_nxt;
      r_stop       <= w_stop_nxt;
      r_reset      <= w_reset_nxt;
      r_busy       <= w_busy_nxt;
      r_nack       <= w_nack_nxt;
    end
  end

  assign req_ready   = r_req_ready;
  assign resp_valid  = r_resp_valid;
  assign resp_ok     = r_resp_ok;
  assign resp_state  = r_resp_state;
  assign start_pulse = r_start;
  assign stop_pulse  = r_stop;
  assign reset_pulse = r_reset;
  assign busy        = r_busy;
  assign nack_count  = r_nack;

endmodule

// File: tb/tb_stopwatch_cmd_arbiter.sv
module tb_stopwatch_cmd_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // dut1: settle window of 1 cycle
  logic [1:0] req_valid, req_ready, resp_valid;
  logic [3:0] req_cmd;
  logic       resp_ok, start_pulse, stop_pulse, reset_pulse, busy;
  logic [1:0] resp_state, fsm_state;
  logic [7:0] nack_count;

  // dut3: settle window of 3 cycles
  logic [1:0] req_valid_3, req_ready_3, resp_valid_3;
  logic [3:0] req_cmd_3;
  logic       resp_ok_3, start_pulse_3, stop_pulse_3, reset_pulse_3, busy_3;
  logic [1:0] resp_state_3, fsm_state_3;
  logic [7:0] nack_count_3;

  stopwatch_cmd_arbiter #(.NUM_SRC(2), .SETTLE_CYCLES(1)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_cmd(req_cmd),
    .req_ready(req_ready), .resp_valid(resp_valid), .resp_ok(resp_ok),
    .resp_state(resp_state), .fsm_state(fsm_state), .start_pulse(start_pulse),
    .stop_pulse(stop_pulse), .reset_pulse(reset_pulse), .busy(busy),
    .nack_count(nack_count)
  );

  stopwatch_cmd_arbiter #(.NUM_SRC(2), .SETTLE_CYCLES(3)) dut3 (
    .clk(clk), .rst(rst), .req_valid(req_valid_3), .req_cmd(req_cmd_3),
    .req_ready(req_ready_3), .resp_valid(resp_valid_3), .resp_ok(resp_ok_3),
    .resp_state(resp_state_3), .fsm_state(fsm_state_3), .start_pulse(start_pulse_3),
    .stop_pulse(stop_pulse_3), .reset_pulse(reset_pulse_3), .busy(busy_3),
    .nack_count(nack_count_3)
  );

  logic [2:0] pulses, pulses_3;
  assign pulses   = {start_pulse, stop_pulse, reset_pulse};
  assign pulses_3 = {start_pulse_3, stop_pulse_3, reset_pulse_3};

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    assert (act === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] exp_grant;
    logic [2:0] seen;
    int n;
    int bad_lat, grant_miss;

    rst = 1'b1;
    req_valid = '0; req_cmd = '0; fsm_state = 2'b00;
    req_valid_3 = '0; req_cmd_3 = '0; fsm_state_3 = 2'b00;
    tick(); tick();

    // Values while reset is held
    check("rst_ready", 32'(req_ready), 32'h0);
    check("rst_resp_valid", 32'(resp_valid), 32'h0);
    check("rst_resp_ok_state", 32'({resp_ok, resp_state}), 32'h0);
    check("rst_pulses", 32'(pulses), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_nack", 32'(nack_count), 32'h0);
    check("rst_nack_3", 32'(nack_count_3), 32'h0);
    rst = 1'b0;
    tick();

    // Basic START from src0 while the FSM is IDLE
    req_valid = 2'b01; req_cmd = 4'b0001; fsm_state = 2'b00;
    tick();  // T
    check("start_ready", 32'(req_ready), 32'h1);
    check("start_busy", 32'(busy), 32'h1);
    req_valid = '0; req_cmd = '0;
    tick();  // T+1
    check("start_pulse_t1", 32'(pulses), 32'h0);
    tick();  // T+2
    check("start_pulse_t2", 32'(pulses), 32'b100);
    tick();  // T+3
    check("start_resp_valid", 32'(resp_valid), 32'h1);
    check("start_resp_ok", 32'(resp_ok), 32'h1);
    check("start_resp_state", 32'(resp_state), 32'h0);
    check("start_pulse_t3", 32'(pulses), 32'h0);
    check("start_busy_done", 32'(busy), 32'h0);

    // Illegal STOP from src1 while the FSM is IDLE
    req_valid = 2'b10; req_cmd = 4'b1000;
    tick();
    check("nack_ready", 32'(req_ready), 32'h2);
    req_valid = '0; req_cmd = '0;
    tick();
    check("nack_pulse_t1", 32'(pulses), 32'h0);
    tick();
    check("nack_pulse_t2", 32'(pulses), 32'h0);
    tick();
    check("nack_resp_valid", 32'(resp_valid), 32'h2);
    check("nack_resp_ok", 32'(resp_ok), 32'h0);
    check("nack_resp_state", 32'(resp_state), 32'h0);
    check("nack_count_1", 32'(nack_count), 32'h1);

    // CLEAR wins even though the pointer is at 0: src0 sends START, src1 sends CLEAR
    req_valid = 2'b11; req_cmd = 4'b1101;
    tick();
    check("clr_prio_ready", 32'(req_ready), 32'h2);
    req_valid = '0; req_cmd = '0;
    tick(); tick();
    check("clr_prio_pulse", 32'(pulses), 32'b001);
    tick();
    check("clr_prio_resp", 32'({resp_valid, resp_ok}), 32'b101);
    check("clr_prio_nack", 32'(nack_count), 32'h1);

    // Fairness: both sources hold START; grants must alternate
    req_valid = 2'b11; req_cmd = 4'b0101; fsm_state = 2'b00;
    exp_grant = 2'b01;
    for (int g = 0; g < 4; g++) begin
      n = 0;
      do begin tick(); n++; end while (req_ready == 2'b00 && n < 10);
      check("fair_grant", 32'(req_ready), 32'(exp_grant));
      fsm_state = (fsm_state == 2'b00) ? 2'b10 : 2'b00;
      n = 0;
      do begin tick(); n++; end while (resp_valid == 2'b00 && n < 10);
      check("fair_resp", 32'({resp_valid, resp_ok}), 32'({exp_grant, 1'b1}));
      exp_grant = ~exp_grant;
    end
    req_valid = '0; req_cmd = '0;

    // CLEAR is legal in the invalid FSM state 11; resp_state reports 11
    fsm_state = 2'b11;
    req_valid = 2'b10; req_cmd = 4'b1100;
    tick();
    check("clr11_ready", 32'(req_ready), 32'h2);
    req_valid = '0; req_cmd = '0;
    tick(); tick();
    check("clr11_pulse", 32'(pulses), 32'b001);
    tick();
    check("clr11_resp", 32'({resp_valid, resp_ok, resp_state}), 32'b10111);
    fsm_state = 2'b00;

    // NOP from src0: accepted, no pulse. The pointer moves to 1.
    req_valid = 2'b01; req_cmd = 4'b0000;
    tick();
    check("nop_ready", 32'(req_ready), 32'h1);
    req_valid = '0;
    tick(); tick();
    check("nop_pulse", 32'(pulses), 32'h0);
    tick();
    check("nop_resp", 32'({resp_valid, resp_ok}), 32'b011);

    // Reset in the middle of ARB_WAIT aborts the transaction and clears the pointer
    req_valid = 2'b01; req_cmd = 4'b0001;
    tick();  // T: grant
    req_valid = '0; req_cmd = '0;
    tick();  // T+1: in ARB_WAIT
    rst = 1'b1;
    #1;
    check("midrst_outputs", 32'({req_ready, resp_valid, resp_ok, resp_state, pulses}), 32'h0);
    check("midrst_busy_nack", 32'({busy, nack_count}), 32'h0);
    tick();
    rst = 1'b0;
    seen = '0;
    for (int c = 0; c < 4; c++) begin
      tick();
      seen = seen | pulses | {1'b0, resp_valid};
    end
    check("midrst_no_resp_or_pulse", 32'(seen), 32'h0);
    req_valid = 2'b11; req_cmd = 4'b0101;
    tick();
    check("midrst_next_grant", 32'(req_ready), 32'h1);
    req_valid = '0; req_cmd = '0;
    tick(); tick(); tick();
    check("midrst_next_resp", 32'(resp_valid), 32'h1);

    // Saturation with a 3-cycle settle window: 260 illegal STOPs while the FSM is IDLE
    fsm_state_3 = 2'b00;
    bad_lat = 0; grant_miss = 0; seen = '0;
    for (int i = 0; i < 260; i++) begin
      req_valid_3 = 2'b01; req_cmd_3 = 4'b0010;
      tick();
      if (req_ready_3 != 2'b01) grant_miss++;
      req_valid_3 = '0; req_cmd_3 = '0;
      n = 0;
      do begin tick(); n++; seen = seen | pulses_3; end
        while (resp_valid_3 == 2'b00 && n < 20);
      if (n != 5) bad_lat++;
      if (i == 0) begin
        check("sat_first_nack", 32'(nack_count_3), 32'h1);
        check("sat_first_ok", 32'(resp_ok_3), 32'h0);
      end
      if (i == 254) check("sat_reach_255", 32'(nack_count_3), 32'd255);
    end
    check("sat_final_255", 32'(nack_count_3), 32'd255);
    check("sat_resp_latency", 32'(bad_lat), 32'h0);
    check("sat_grants", 32'(grant_miss), 32'h0);
    check("sat_no_pulse", 32'(seen), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
